// File: rtl/cdb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_rr_arbiter
//   Arbitrates NUM_CH functional-unit producers onto a single common data bus
//   (CDB). The selected producer sees a combinational one-hot accept in the
//   cycle it wins. Its data and label are broadcast from registers on the
//   following cycle. Arbitration is round-robin when RR_MODE=1 and fixed
//   priority (channel 0 highest) when RR_MODE=0.
//
// Parameters
//   NUM_CH   number of producers (2..8)
//   DATA_W   broadcast data width
//   LABEL_W  reservation-station label width (label 0 is never a producer)
//   RR_MODE  1 = round-robin, 0 = fixed priority
//
// Ports
//   clk       in   clock, rising edge
//   RST       in   synchronous active-high reset
//   require   in   [NUM_CH]          per-channel broadcast request
//   dataIn    in   [NUM_CH*DATA_W]   channel i data at [i*DATA_W +: DATA_W]
//   labelIn   in   [NUM_CH*LABEL_W]  channel i label at [i*LABEL_W +: LABEL_W]
//   accept    out  [NUM_CH]          one-hot grant (combinational)
//   BCEN      out  broadcast valid (registered)
//   BCdata    out  [DATA_W]          broadcast data (registered)
//   BClabel   out  [LABEL_W]         broadcast label (registered)
//   protoErr  out  sticky protocol-violation flag (registered)
// -----------------------------------------------------------------------------
module cdb_rr_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int LABEL_W = 4,
  parameter int RR_MODE = 1
) (
  input  logic                        clk,
  input  logic                        RST,
  input  logic [NUM_CH-1:0]           require,
  input  logic [NUM_CH*DATA_W-1:0]    dataIn,
  input  logic [NUM_CH*LABEL_W-1:0]   labelIn,
  output logic [NUM_CH-1:0]           accept,
  output logic                        BCEN,
  output logic [DATA_W-1:0]           BCdata,
  output logic [LABEL_W-1:0]          BClabel,
  output logic                        protoErr
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               bcen_q, bcen_d;
  logic [DATA_W-1:0]  bcdata_q, bcdata_d;
  logic [LABEL_W-1:0] bclabel_q, bclabel_d;
  logic               perr_q, perr_d;
  // Channels that requested without being accepted in the previous cycle.
  logic [NUM_CH-1:0]  pend_q, pend_d;

  logic [NUM_CH-1:0]  zero_lbl_s;
  logic [NUM_CH-1:0]  elig_s;
  logic [NUM_CH-1:0]  grant_s;
  logic [PTR_W-1:0]   scan_base_s;
  logic [PTR_W:0]     cand_sum_s;
  logic [PTR_W-1:0]   cand_idx_s;
  logic               grant_vld_s;
  logic [PTR_W-1:0]   grant_idx_s;

  // Per-channel eligibility: a request counts only with a non-zero label.
  always_comb begin
    zero_lbl_s = '0;
    elig_s     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      zero_lbl_s[i] = (labelIn[i*LABEL_W +: LABEL_W] == {LABEL_W{1'b0}});
      elig_s[i]     = require[i] & ~zero_lbl_s[i];
    end
  end

  // Scan start: the rotating pointer in round-robin mode, channel 0 otherwise.
  always_comb begin
    scan_base_s = '0;
    if (RR_MODE != 0) begin
      scan_base_s = ptr_q;
    end else begin
      scan_base_s = '0;
    end
  end

  // Circular scan from scan_base_s; the first eligible channel wins.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_sum_s  = '0;
    cand_idx_s  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand_sum_s = {1'b0, scan_base_s} + (PTR_W+1)'(k);
      // Wrap modulo NUM_CH; the sum never reaches 2*NUM_CH.
      if (cand_sum_s >= (PTR_W+1)'(NUM_CH)) begin
        cand_sum_s = cand_sum_s - (PTR_W+1)'(NUM_CH);
      end else begin
        cand_sum_s = cand_sum_s;
      end
      cand_idx_s = cand_sum_s[PTR_W-1:0];
      if (!grant_vld_s && elig_s[cand_idx_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_idx_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // One-hot accept, forced low while reset is asserted.
  always_comb begin
    grant_s = '0;
    if (grant_vld_s && !RST) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign accept = grant_s;

  // Next-state: broadcast registers, pointer advance and protocol monitor.
  always_comb begin
    ptr_d     = ptr_q;
    bcen_d    = 1'b0;
    bcdata_d  = '0;
    bclabel_d = '0;
    pend_d    = require & ~grant_s;
    // Sticky: a pending request dropped before accept, or a label-0 request.
    perr_d    = perr_q | (|(pend_q & ~require)) | (|(require & zero_lbl_s));
    if (grant_vld_s) begin
      bcen_d    = 1'b1;
      bcdata_d  = dataIn[int'(grant_idx_s)*DATA_W +: DATA_W];
      bclabel_d = labelIn[int'(grant_idx_s)*LABEL_W +: LABEL_W];
      if (RR_MODE != 0) begin
        if (grant_idx_s == PTR_W'(NUM_CH-1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = grant_idx_s + PTR_W'(1);
        end
      end else begin
        ptr_d = '0;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      ptr_q     <= '0;
      bcen_q    <= 1'b0;
      bcdata_q  <= '0;
      bclabel_q <= '0;
      perr_q    <= 1'b0;
      pend_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      bcen_q    <= bcen_d;
      bcdata_q  <= bcdata_d;
      bclabel_q <= bclabel_d;
      perr_q    <= perr_d;
      pend_q    <= pend_d;
    end
  end

  assign BCEN     = bcen_q;
  assign BCdata   = bcdata_q;
  assign BClabel  = bclabel_q;
  assign protoErr = perr_q;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_rr_arbiter
//   Self-checking bench for cdb_rr_arbiter. Five instances (4-ch round-robin,
//   4-ch fixed priority, and 2/5/8-ch round-robin) share one stimulus bus.
//   One instance is selected at a time and compared against a behavioural
//   model of the arbitration, broadcast and protocol-error rules.
// -----------------------------------------------------------------------------
module tb_cdb_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [7:0]        req;
  logic [8*32-1:0]   din;
  logic [8*4-1:0]    lin;

  logic [3:0] acc_a; logic bcen_a; logic [31:0] bcd_a; logic [3:0] bcl_a; logic perr_a;
  logic [3:0] acc_b; logic bcen_b; logic [31:0] bcd_b; logic [3:0] bcl_b; logic perr_b;
  logic [1:0] acc_c; logic bcen_c; logic [31:0] bcd_c; logic [3:0] bcl_c; logic perr_c;
  logic [4:0] acc_d; logic bcen_d; logic [31:0] bcd_d; logic [3:0] bcl_d; logic perr_d;
  logic [7:0] acc_e; logic bcen_e; logic [31:0] bcd_e; logic [3:0] bcl_e; logic perr_e;

  cdb_rr_arbiter #(.NUM_CH(4), .DATA_W(32), .LABEL_W(4), .RR_MODE(1)) u_rr4 (
    .clk(clk), .RST(rst), .require(req[3:0]), .dataIn(din[4*32-1:0]), .labelIn(lin[4*4-1:0]),
    .accept(acc_a), .BCEN(bcen_a), .BCdata(bcd_a), .BClabel(bcl_a), .protoErr(perr_a));
  cdb_rr_arbiter #(.NUM_CH(4), .DATA_W(32), .LABEL_W(4), .RR_MODE(0)) u_fp4 (
    .clk(clk), .RST(rst), .require(req[3:0]), .dataIn(din[4*32-1:0]), .labelIn(lin[4*4-1:0]),
    .accept(acc_b), .BCEN(bcen_b), .BCdata(bcd_b), .BClabel(bcl_b), .protoErr(perr_b));
  cdb_rr_arbiter #(.NUM_CH(2), .DATA_W(32), .LABEL_W(4), .RR_MODE(1)) u_rr2 (
    .clk(clk), .RST(rst), .require(req[1:0]), .dataIn(din[2*32-1:0]), .labelIn(lin[2*4-1:0]),
    .accept(acc_c), .BCEN(bcen_c), .BCdata(bcd_c), .BClabel(bcl_c), .protoErr(perr_c));
  cdb_rr_arbiter #(.NUM_CH(5), .DATA_W(32), .LABEL_W(4), .RR_MODE(1)) u_rr5 (
    .clk(clk), .RST(rst), .require(req[4:0]), .dataIn(din[5*32-1:0]), .labelIn(lin[5*4-1:0]),
    .accept(acc_d), .BCEN(bcen_d), .BCdata(bcd_d), .BClabel(bcl_d), .protoErr(perr_d));
  cdb_rr_arbiter #(.NUM_CH(8), .DATA_W(32), .LABEL_W(4), .RR_MODE(1)) u_rr8 (
    .clk(clk), .RST(rst), .require(req[7:0]), .dataIn(din[8*32-1:0]), .labelIn(lin[8*4-1:0]),
    .accept(acc_e), .BCEN(bcen_e), .BCdata(bcd_e), .BClabel(bcl_e), .protoErr(perr_e));

  int sel;
  int n_ch;
  int rr_mode;

  logic [7:0]  acc_s;
  logic        bcen_s;
  logic [31:0] bcd_s;
  logic [3:0]  bcl_s;
  logic        perr_s;

  // Route the selected instance's outputs to common observation signals.
  always_comb begin
    acc_s = 8'd0; bcen_s = 1'b0; bcd_s = 32'd0; bcl_s = 4'd0; perr_s = 1'b0;
    case (sel)
      0: begin acc_s = {4'd0, acc_a}; bcen_s = bcen_a; bcd_s = bcd_a; bcl_s = bcl_a; perr_s = perr_a; end
      1: begin acc_s = {4'd0, acc_b}; bcen_s = bcen_b; bcd_s = bcd_b; bcl_s = bcl_b; perr_s = perr_b; end
      2: begin acc_s = {6'd0, acc_c}; bcen_s = bcen_c; bcd_s = bcd_c; bcl_s = bcl_c; perr_s = perr_c; end
      3: begin acc_s = {3'd0, acc_d}; bcen_s = bcen_d; bcd_s = bcd_d; bcl_s = bcl_d; perr_s = perr_d; end
      4: begin acc_s = acc_e; bcen_s = bcen_e; bcd_s = bcd_e; bcl_s = bcl_e; perr_s = perr_e; end
      default: begin acc_s = 8'd0; end
    endcase
  end

  int n_err = 0;
  int n_checks = 0;

  // Reference model state
  int          m_ptr;
  logic        m_bcen;
  logic [31:0] m_bcd;
  logic [3:0]  m_bcl;
  logic        m_perr;
  logic [7:0]  m_pend;
  int          m_g;
  int          waitc [8];
  logic [7:0]  last_acc;
  logic [7:0]  hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner by the arbitration rule: first eligible channel scanning from the
  // pointer (round-robin) or from channel 0 (fixed priority).
  function automatic int model_grant();
    int c;
    if (rst) return -1;
    for (int k = 0; k < n_ch; k++) begin
      c = (rr_mode == 1) ? (m_ptr + k) % n_ch : k;
      if (req[c] && lin[c*4 +: 4] != 4'd0) return c;
    end
    return -1;
  endfunction

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    logic [7:0] exp_acc;
    #3;
    m_g = model_grant();
    exp_acc = (m_g >= 0) ? (8'd1 << m_g) : 8'd0;
    last_acc = acc_s;
    chk("accept", acc_s, exp_acc);
    chk("onehot", ($countones(acc_s) <= 1), 1'b1);
    chk("bcen", bcen_s, m_bcen);
    chk("bcdata", bcd_s, m_bcd);
    chk("bclabel", bcl_s, m_bcl);
    chk("protoerr", perr_s, m_perr);
    for (int i = 0; i < 8; i++) begin
      if (i < n_ch && !rst && req[i] && lin[i*4 +: 4] != 4'd0 && !acc_s[i]) waitc[i]++;
      else waitc[i] = 0;
      if (rr_mode == 1 && waitc[i] > 0) chk("wait_bound", (waitc[i] < n_ch), 1'b1);
    end
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_bcen = 1'b0; m_bcd = 32'd0; m_bcl = 4'd0; m_perr = 1'b0; m_pend = 8'd0;
    end else begin
      for (int i = 0; i < n_ch; i++) begin
        if (m_pend[i] && !req[i]) m_perr = 1'b1;
        if (req[i] && lin[i*4 +: 4] == 4'd0) m_perr = 1'b1;
      end
      if (m_g >= 0) begin
        m_bcen = 1'b1; m_bcd = din[m_g*32 +: 32]; m_bcl = lin[m_g*4 +: 4];
        m_ptr = (rr_mode == 1) ? (m_g + 1) % n_ch : 0;
      end else begin
        m_bcen = 1'b0; m_bcd = 32'd0; m_bcl = 4'd0;
      end
      m_pend = 8'd0;
      for (int i = 0; i < n_ch; i++) m_pend[i] = req[i] && (m_g != i);
    end
    #1;
  endtask

  // Select an instance, reset it, and check the reset state.
  task automatic phase_start(input int s);
    sel = s;
    n_ch = (s == 2) ? 2 : (s == 3) ? 5 : (s == 4) ? 8 : 4;
    rr_mode = (s == 1) ? 0 : 1;
    rst = 1'b1; req = 8'd0; din = '0; lin = '0; hold = 8'd0;
    for (int i = 0; i < 8; i++) waitc[i] = 0;
    @(posedge clk);
    #1;
    m_ptr = 0; m_bcen = 1'b0; m_bcd = 32'd0; m_bcl = 4'd0; m_perr = 1'b0; m_pend = 8'd0;
    step();
    rst = 1'b0;
  endtask

  task automatic run_random(input int s, input int cycles);
    phase_start(s);
    for (int t = 0; t < cycles; t++) begin
      for (int i = 0; i < 8; i++) begin
        if (i >= n_ch) begin
          req[i] = 1'b0;
        end else if (!hold[i]) begin
          req[i] = 1'($urandom_range(0, 1));
          lin[i*4 +: 4] = 4'($urandom_range(1, 15));
          din[i*32 +: 32] = $urandom;
        end
      end
      step();
      for (int i = 0; i < 8; i++) hold[i] = req[i] && (m_g != i);
    end
  endtask

  initial begin
    rst = 1'b1; req = 8'd0; din = '0; lin = '0; sel = 0; n_ch = 4; rr_mode = 1;

    // Reset state and round-robin rotation with all four channels requesting
    phase_start(0);
    chk("rst_bcen", bcen_s, 1'b0);
    chk("rst_perr", perr_s, 1'b0);
    lin[15:0] = {4'd4, 4'd3, 4'd2, 4'd1};
    for (int i = 0; i < 4; i++) din[i*32 +: 32] = $urandom;
    req = 8'h0F;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_seq_acc", last_acc, 8'd1 << (k % 4));
      chk("rr_seq_lbl", bcl_s, 4'((k % 4) + 1));
      chk("rr_seq_bcen", bcen_s, 1'b1);
      if (m_g >= 0) din[m_g*32 +: 32] = $urandom;
    end

    // Fixed priority: channel 1 always beats channel 3
    phase_start(1);
    lin[15:0] = {4'd9, 4'd0, 4'd3, 4'd0};
    req = 8'h0A;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("fp_acc", last_acc, 8'h02);
    end

    // Single request, one-cycle broadcast latency, then zeros
    phase_start(0);
    din[2*32 +: 32] = 32'hDEADBEEF;
    lin[2*4 +: 4] = 4'd7;
    req = 8'h04;
    step();
    chk("single_acc", last_acc, 8'h04);
    chk("single_bcen", bcen_s, 1'b1);
    chk("single_bcd", bcd_s, 32'hDEADBEEF);
    chk("single_bcl", bcl_s, 4'd7);
    req = 8'h00;
    step();
    chk("single_bcen0", bcen_s, 1'b0);
    chk("single_bcd0", bcd_s, 32'd0);
    chk("single_bcl0", bcl_s, 4'd0);

    // Dropped request: channel 1 withdraws before being accepted
    phase_start(0);
    lin[3:0] = 4'd1; lin[7:4] = 4'd5;
    req = 8'h03;
    step();
    chk("drop_acc", last_acc, 8'h01);
    req = 8'h00;
    step();
    chk("drop_perr", perr_s, 1'b1);
    for (int k = 0; k < 3; k++) step();
    chk("drop_perr_sticky", perr_s, 1'b1);

    // Label-0 request is never accepted and flags an error
    phase_start(0);
    lin[15:12] = 4'd0;
    req = 8'h08;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("lbl0_acc3", last_acc[3], 1'b0);
    end
    chk("lbl0_perr", perr_s, 1'b1);

    // Reset mid-stream with ptr=3 and requests on channels 1 and 2
    phase_start(0);
    lin[2*4 +: 4] = 4'd6; din[2*32 +: 32] = 32'h1234_5678;
    req = 8'h04;
    step();
    chk("mid_pre_bcen", bcen_s, 1'b1);
    rst = 1'b1;
    lin[1*4 +: 4] = 4'd3; din[1*32 +: 32] = 32'hCAFE_0001;
    req = 8'h06;
    step();
    chk("mid_rst_acc1", last_acc, 8'h00);
    chk("mid_rst_bcen", bcen_s, 1'b0);
    step();
    chk("mid_rst_acc2", last_acc, 8'h00);
    rst = 1'b0;
    step();
    chk("mid_rel_acc1", last_acc, 8'h02);
    step();
    chk("mid_rel_acc2", last_acc, 8'h04);

    // Random traffic on every configuration
    run_random(0, 200);
    run_random(1, 100);
    run_random(2, 200);
    run_random(3, 200);
    run_random(4, 200);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
